// File: rtl/data_ram.sv
// rtl/data_ram.sv - 1024 x 32 flip-flop data memory with sync write, gated combinational read, async clear
module data_ram (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [9:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    localparam int DEPTH = 1024;
    localparam int WIDTH = 32;

    // Built from flops rather than a RAM macro so every word can clear asynchronously.
    logic [WIDTH-1:0] mem [DEPTH];

    // Whole array clears the moment RST rises; otherwise one word is written per enabled edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (MemWrite) begin
            mem[address] <= write_data;
        end
    end

    // Zero-latency read, forced to zero when not enabled; no write bypass, so a
    // same-address write shows up only after its edge.
    always_comb begin
        read_data = '0;
        if (MemRead) begin
            read_data = mem[address];
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// tb/tb_data_ram.sv - directed scoreboard bench for data_ram
module tb_data_ram;

    logic        CLK;
    logic        RST;
    logic        MemWrite;
    logic        MemRead;
    logic [9:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int passed;
    int total;

    logic [31:0] exp_q [$];
    logic [31:0] model [1024];

    data_ram dut (
        .CLK        (CLK),
        .RST        (RST),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_pop(input string tag);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: scoreboard empty, observed %h", tag, read_data);
        end else begin
            e = exp_q.pop_front();
            assert (read_data === e) passed++;
            else $error("FAIL %s: observed %h expected %h", tag, read_data, e);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) model[i] = 32'd0;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d);
        @(negedge CLK);
        address    = a;
        write_data = d;
        MemWrite   = 1'b1;
        MemRead    = 1'b0;
        @(negedge CLK);
        MemWrite   = 1'b0;
        if (!RST) model[a] = d;
    endtask

    task automatic do_read(input logic [9:0] a, input string tag);
        @(negedge CLK);
        address = a;
        MemRead = 1'b1;
        push_exp(model[a]);
        #4;
        check_pop(tag);
    endtask

    initial begin
        logic [9:0]  ra;
        logic [31:0] rd;
        passed = 0;
        total  = 0;
        clear_model();
        RST = 1'b1;
        MemWrite = 1'b0;
        MemRead = 1'b1;
        address = 10'd0;
        write_data = 32'd0;

        // reset held for two cycles
        repeat (2) @(posedge CLK);
        #1;
        push_exp(32'd0);
        check_pop("reset_hold_read");
        @(negedge CLK);
        RST = 1'b0;
        do_read(10'd0,    "reset_addr0");
        do_read(10'd511,  "reset_addr511");
        do_read(10'd1023, "reset_addr1023");

        // write then read
        do_write(10'h155, 32'hDEADBEEF);
        do_read(10'h155, "wr_rd_155");
        for (int k = 0; k < 3; k++) begin
            ra = 10'($urandom_range(16, 1000));
            rd = $urandom;
            do_write(ra, rd);
            do_read(ra, $sformatf("wr_rd_rand%0d", k));
        end
        do_read(10'h155, "wr_rd_155_again");

        // read gating without a clock edge
        @(negedge CLK);
        address = 10'h155;
        MemRead = 1'b0;
        #1;
        push_exp(32'd0);
        check_pop("gate_off");
        MemRead = 1'b1;
        #1;
        push_exp(32'hDEADBEEF);
        check_pop("gate_on");

        // independence and hold
        do_write(10'd0,    32'h11111111);
        do_write(10'd1023, 32'h22222222);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            MemWrite   = 1'b0;
            write_data = (k % 2 == 0) ? 32'hFFFFFFFF : 32'h00000000;
            address    = 10'(k);
        end
        do_read(10'd0,    "hold_addr0");
        do_read(10'd1023, "hold_addr1023");

        // read during write
        do_write(10'd5, 32'hA5A5A5A5);
        @(negedge CLK);
        address    = 10'd5;
        MemRead    = 1'b1;
        MemWrite   = 1'b1;
        write_data = 32'h5A5A5A5A;
        push_exp(32'hA5A5A5A5);
        #4;
        check_pop("rdw_before_edge");
        model[5] = 32'h5A5A5A5A;
        push_exp(model[5]);
        @(posedge CLK);
        #1;
        check_pop("rdw_after_edge");
        @(negedge CLK);
        MemWrite = 1'b0;

        // asynchronous reset mid-cycle
        do_read(10'h155, "pre_reset_155");
        @(negedge CLK);
        #2;
        RST = 1'b1;
        clear_model();
        #1;
        push_exp(32'd0);
        check_pop("async_reset_drop");
        address = 10'd5;
        #1;
        push_exp(32'd0);
        check_pop("async_reset_addr5");
        // write attempted while reset held
        @(negedge CLK);
        address    = 10'h155;
        write_data = 32'hCAFEF00D;
        MemWrite   = 1'b1;
        @(posedge CLK);
        #1;
        push_exp(32'd0);
        check_pop("write_during_reset");
        @(negedge CLK);
        MemWrite = 1'b0;
        RST      = 1'b0;
        do_read(10'h155, "after_release_155");
        do_read(10'd0,   "after_release_addr0");
        // first edge after release accepts writes
        do_write(10'h155, 32'h0BADCAFE);
        do_read(10'h155, "first_write_after_release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
